rr_packet_arbiter: RTL

// Shares one downstream valid/ready stream among NUM_REQ packet sources.

---
 rtl/rr_packet_arbiter_pkg.sv | 11 +
 rtl/rr_packet_arbiter_if.sv | 29 ++
 rtl/rr_packet_arbiter_rr_pick.sv | 34 +++
 rtl/rr_packet_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/rr_packet_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_packet_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    // Wrap-around increment of a source index in the range 0..n-1.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Upstream packet sources and downstream stream of the round-robin arbiter.
interface rr_packet_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_ready;
    logic                      out_valid;
    logic                      out_last;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_id, busy
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_id, busy
    );

endinterface

// File: rtl/rr_packet_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);
    localparam int ID_W = $clog2(N);
    localparam int W2   = 2 * N;

    logic [W2-1:0] dbl;
    logic [W2-1:0] mask;
    logic [W2-1:0] masked;
    logic [W2-1:0] onehot;

    // The upper copy is never masked, so wrap-around candidates are still found.
    always_comb begin
        dbl    = {req, req};
        mask   = ~((W2'(1) << ptr) - W2'(1));
        masked = dbl & mask;
        onehot = masked & (~masked + W2'(1));
        idx    = '0;
        for (int p = 0; p < W2; p++) begin
            if (onehot[p]) begin
                idx = ID_W'(p % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter that locks the downstream stream to one source for a whole packet.
//   state    | meaning
//   ARB_IDLE | no owner; pick next requester from ptr, outputs all zero
//   ARB_LOCK | source gid owns the stream until its last beat transfers
module rr_packet_arbiter
    import rr_packet_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    rr_packet_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gid_q, gid_d;

    logic               pick_any;
    logic [ID_W-1:0]    pick_idx;

    logic [NUM_REQ-1:0] in_ready_c;
    logic               out_valid_c;
    logic               out_last_c;
    logic [DATA_W-1:0]  out_data_c;
    logic [ID_W-1:0]    out_id_c;
    logic               busy_c;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.in_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        in_ready_c  = '0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_data_c  = '0;
        out_id_c    = '0;
        busy_c      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gid_d   = pick_idx;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                busy_c            = 1'b1;
                out_id_c          = gid_q;
                out_valid_c       = bus.in_valid[gid_q];
                out_last_c        = bus.in_last[gid_q];
                out_data_c        = bus.in_data[int'(gid_q)*DATA_W +: DATA_W];
                in_ready_c[gid_q] = bus.out_ready;
                // Releasing only on the last transfer keeps packets from interleaving.
                if (out_valid_c && bus.out_ready && out_last_c) begin
                    ptr_d   = ID_W'(rr_next(int'(gid_q), NUM_REQ));
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_id    = out_id_c;
    assign bus.busy      = busy_c;

endmodule
